// File: rtl/debug_ocimem_pkg.sv
// Shared definitions for the debug OCI memory engine: FSM states, jdo field
// positions and default parameter values.
package debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } ocimem_state_e;

  localparam int JDO_W      = 38;
  localparam int WDATA_LSB  = 3;
  localparam int WDATA_MSB  = 34;
  localparam int RDFLAG_BIT = 35;

  localparam int DEFAULT_ADDR_W         = 10;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/debug_ocimem_timeout.sv
// Counts consecutive stalled cycles of a memory access and flags the cycle in
// which the stall limit is reached.
module debug_ocimem_timeout
  import debug_ocimem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  // The stall that would be number TIMEOUT_CYCLES is the one that aborts.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/debug_ocimem_engine.sv
// JTAG debug engine that turns take_* strobes into single word accesses on an
// Avalon-MM style debug memory port, with a stall timeout.
module debug_ocimem_engine
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_e     state;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              any_strobe;
  logic              stall_run;
  logic              stall_expired;
  logic [1:0]        unused_jdo;

  assign busy       = (state != ST_IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign stall_run  = busy && avm_waitrequest;
  assign avm_address = addr;
  assign unused_jdo = jdo[JDO_W-1:RDFLAG_BIT+1];

  debug_ocimem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (stall_run),
    .clear  (!stall_run),
    .expired(stall_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      MonDReg       <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_b) begin
            avm_writedata <= jdo[WDATA_MSB:WDATA_LSB];
            avm_write     <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            state         <= ST_WRITE;
          end else if (take_action_ocimem_a) begin
            // A plain address load completes immediately; with the read flag
            // the read goes to the freshly loaded address.
            addr          <= jdo[ADDR_W-1:0];
            monitor_ready <= !jdo[RDFLAG_BIT];
            monitor_error <= 1'b0;
            if (jdo[RDFLAG_BIT]) begin
              avm_read <= 1'b1;
              state    <= ST_READ;
            end
          end else if (take_no_action_ocimem_a) begin
            avm_read      <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            state         <= ST_READ;
          end
        end

        ST_READ, ST_WRITE: begin
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          if (!avm_waitrequest) begin
            MonDReg       <= (state == ST_READ) ? avm_readdata : avm_writedata;
            addr          <= addr + 1'b1;
            monitor_ready <= 1'b1;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            state         <= ST_IDLE;
          end else if (stall_expired) begin
            // Abort leaves MonDReg and the address untouched.
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  a_req_exclusive: assert property (@(posedge clk) disable iff (reset) !(avm_read && avm_write));

endmodule

// File: tb/tb_debug_ocimem_engine.sv
// Self-checking bench for debug_ocimem_engine: directed vector table, random
// commands against a transaction-level model, and reset/collision sequences.
module tb_debug_ocimem_engine;
  import debug_ocimem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int TMO    = 255;

  typedef enum int {CMD_A, CMD_B, CMD_N} cmd_e;

  typedef struct {
    cmd_e        kind;
    logic [37:0] jdo;
    int          waits;
    logic [31:0] e_mon;
    logic [9:0]  e_addr;
    logic        e_rdy;
    logic        e_err;
    int          e_req;
    logic        e_rd;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_a, take_b, take_n;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata, avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] slave_mem [1024];
  logic [31:0] model_mem [1024];

  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_mon, m_wd;
  logic              m_ready, m_err, m_rd;
  int                m_req;

  int                obs_req;
  logic              obs_stable, rd_seen, wr_seen, rdy0, err0;
  logic [ADDR_W-1:0] a0;
  logic [31:0]       d0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  debug_ocimem_engine #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_a),
    .take_action_ocimem_b   (take_b),
    .take_no_action_ocimem_a(take_n),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  function automatic logic [37:0] jdo_a(input logic rd, input logic [9:0] a, input logic [1:0] hi);
    return {hi, rd, 25'h1555555, a};
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d, input logic [1:0] hi, input logic rd, input logic [2:0] lo);
    return {hi, rd, d, lo};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: one call = one whole command with its outcome.
  task automatic model_cmd(input cmd_e kind, input logic [37:0] j, input int waits, input bit drop);
    bit access;
    access = (kind != CMD_A) || j[35];
    m_rd   = (kind != CMD_B);
    if (kind == CMD_A) m_addr = j[9:0];
    if (kind == CMD_B) m_wd = j[34:3];
    m_err   = 1'b0;
    m_ready = 1'b1;
    m_req   = 0;
    if (access) begin
      m_req = (waits >= TMO) ? TMO : waits + 1;
      if (waits >= TMO) begin
        m_err = 1'b1;
      end else begin
        if (m_rd) begin
          m_mon = model_mem[m_addr];
        end else begin
          model_mem[m_addr] = m_wd;
          m_mon = m_wd;
        end
        m_addr = m_addr + 1'b1;
      end
      if (drop) m_err = 1'b1;
    end
  endtask

  task automatic applyStimulus(input cmd_e kind, input logic [37:0] j, input int waits,
                               input bit drop, input bit collide);
    jdo    = j;
    take_a = (kind == CMD_A);
    take_b = (kind == CMD_B);
    take_n = (kind == CMD_N) || collide;
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    obs_req = 0; obs_stable = 1'b1; rd_seen = 1'b0; wr_seen = 1'b0;
    rdy0 = 1'b1; err0 = 1'b1;
    for (int c = 0; c < TMO + 20; c++) begin
      if (!(avm_read || avm_write)) break;
      if (c == 0) begin
        a0 = avm_address; d0 = avm_writedata; rdy0 = monitor_ready; err0 = monitor_error;
      end else if (avm_address !== a0 || avm_writedata !== d0) begin
        obs_stable = 1'b0;
      end
      if (avm_read && avm_write) obs_stable = 1'b0;
      if (avm_read) rd_seen = 1'b1;
      if (avm_write) wr_seen = 1'b1;
      obs_req++;
      avm_waitrequest = (c < waits);
      avm_readdata    = slave_mem[avm_address];
      if (avm_write && !avm_waitrequest) slave_mem[avm_address] = avm_writedata;
      if (drop && c == 1) take_n = 1'b1;
      @(posedge clk); #1;
      take_n = 1'b0;
    end
    avm_waitrequest = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [31:0] e_mon, input logic [9:0] e_addr,
                        input logic e_rdy, input logic e_err, input int e_req, input logic e_rd);
    checkOutput({tag, ".mondreg"}, MonDReg, e_mon);
    checkOutput({tag, ".addr"}, 32'(avm_address), 32'(e_addr));
    checkOutput({tag, ".ready"}, 32'(monitor_ready), 32'(e_rdy));
    checkOutput({tag, ".error"}, 32'(monitor_error), 32'(e_err));
    checkOutput({tag, ".req_idle"}, {30'd0, avm_read, avm_write}, 32'd0);
    checkOutput({tag, ".req_cycles"}, 32'(obs_req), 32'(e_req));
    if (e_req > 0) begin
      checkOutput({tag, ".stable"}, 32'(obs_stable), 32'd1);
      checkOutput({tag, ".ready_clr"}, 32'(rdy0), 32'd0);
      checkOutput({tag, ".err_clr"}, 32'(err0), 32'd0);
      checkOutput({tag, ".rd_dir"}, 32'(rd_seen), 32'(e_rd));
      checkOutput({tag, ".wr_dir"}, 32'(wr_seen), 32'(!e_rd));
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, ".mondreg"}, MonDReg, 32'd0);
    checkOutput({tag, ".addr"}, 32'(avm_address), 32'd0);
    checkOutput({tag, ".wdata"}, avm_writedata, 32'd0);
    checkOutput({tag, ".req"}, {30'd0, avm_read, avm_write}, 32'd0);
    checkOutput({tag, ".flags"}, {30'd0, monitor_ready, monitor_error}, 32'd0);
  endtask

  initial begin
    cmd_e        kind;
    logic [37:0] j;
    int          waits, r;
    bit          drop;

    for (int i = 0; i < 1024; i++) begin
      slave_mem[i] = $urandom;
      model_mem[i] = slave_mem[i];
    end
    slave_mem[10'h010] = 32'hDEADBEEF; model_mem[10'h010] = 32'hDEADBEEF;
    slave_mem[10'h020] = 32'hCAFEF00D; model_mem[10'h020] = 32'hCAFEF00D;

    vecs[0] = '{CMD_A, jdo_a(1'b1, 10'h010, 2'b00), 0, 32'hDEADBEEF, 10'h011, 1'b1, 1'b0, 1, 1'b1};
    vecs[1] = '{CMD_A, jdo_a(1'b0, 10'h3FF, 2'b11), 0, 32'hDEADBEEF, 10'h3FF, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{CMD_B, jdo_b(32'h11111111, 2'b11, 1'b1, 3'b111), 0, 32'h11111111, 10'h000, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{CMD_B, jdo_b(32'h22222222, 2'b00, 1'b0, 3'b000), 0, 32'h22222222, 10'h001, 1'b1, 1'b0, 1, 1'b0};
    vecs[4] = '{CMD_A, jdo_a(1'b1, 10'h3FF, 2'b10), 5, 32'h11111111, 10'h000, 1'b1, 1'b0, 6, 1'b1};
    vecs[5] = '{CMD_N, jdo_a(1'b0, 10'h2AA, 2'b01), 0, 32'h22222222, 10'h001, 1'b1, 1'b0, 1, 1'b1};
    vecs[6] = '{CMD_A, jdo_a(1'b1, 10'h020, 2'b00), 300, 32'h22222222, 10'h020, 1'b1, 1'b1, 255, 1'b1};
    vecs[7] = '{CMD_N, jdo_a(1'b1, 10'h100, 2'b00), 2, 32'hCAFEF00D, 10'h021, 1'b1, 1'b0, 3, 1'b1};
    vecs[8] = '{CMD_B, jdo_b(32'hA5A5A5A5, 2'b01, 1'b0, 3'b010), 254, 32'hA5A5A5A5, 10'h022, 1'b1, 1'b0, 255, 1'b0};
    vecs[9] = '{CMD_A, jdo_a(1'b1, 10'h021, 2'b00), 0, 32'hA5A5A5A5, 10'h022, 1'b1, 1'b0, 1, 1'b1};

    reset = 1'b1; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    m_addr = '0; m_mon = '0; m_wd = '0; m_ready = 1'b0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      model_cmd(vecs[i].kind, vecs[i].jdo, vecs[i].waits, 1'b0);
      applyStimulus(vecs[i].kind, vecs[i].jdo, vecs[i].waits, 1'b0, 1'b0);
      verify($sformatf("vec%0d", i), vecs[i].e_mon, vecs[i].e_addr, vecs[i].e_rdy,
             vecs[i].e_err, vecs[i].e_req, vecs[i].e_rd);
    end

    // Write and read strobed together, then a read strobe during the write.
    j = jdo_b(32'h5A5A1234, 2'b00, 1'b1, 3'b000);
    model_cmd(CMD_B, j, 3, 1'b1);
    applyStimulus(CMD_B, j, 3, 1'b1, 1'b1);
    verify("collide", m_mon, m_addr, m_ready, m_err, m_req, m_rd);

    for (int i = 0; i < 60; i++) begin
      kind  = cmd_e'($urandom_range(0, 2));
      j     = {6'($urandom), $urandom};
      r     = $urandom_range(0, 15);
      waits = (r == 0) ? TMO + $urandom_range(0, 3) : (r == 1) ? TMO - 1 : $urandom_range(0, 4);
      drop  = ((kind != CMD_A) || j[35]) && (waits >= 1) && ($urandom_range(0, 3) == 0);
      model_cmd(kind, j, waits, drop);
      applyStimulus(kind, j, waits, drop, 1'b0);
      verify($sformatf("rand%0d", i), m_mon, m_addr, m_ready, m_err, m_req, m_rd);
    end

    // Reset while a read is stalled, with a strobe in the reset cycle.
    jdo = jdo_a(1'b0, 10'h000, 2'b00);
    take_n = 1'b1;
    @(posedge clk); #1;
    take_n = 1'b0;
    avm_waitrequest = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("rst.pre_read", 32'(avm_read), 32'd1);
    reset = 1'b1;
    take_a = 1'b1;
    jdo = jdo_a(1'b1, 10'h155, 2'b00);
    @(posedge clk); #1;
    check_reset_state("rst.mid");
    reset = 1'b0; take_a = 1'b0; avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rst.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/debug_ocimem_engine.md
DEBUG_OCIMEM_ENGINE -- requirements
Module: debug_ocimem_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the debug memory port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of waitrequest cycles before an access aborts.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, the same clock as the JTAG debug sysclk stage.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 jdo  in  38  debug command word, stable while any take_* strobe is high.
REQ-007 take_action_ocimem_a  in  1  one-cycle pulse: load address; jdo[35]=1 also launches a read.
REQ-008 take_action_ocimem_b  in  1  one-cycle pulse: write jdo[34:3] at the current address.
REQ-009 take_no_action_ocimem_a  in  1  one-cycle pulse: read at the current address.
REQ-010 avm_address  out  ADDR_W  word address to the debug memory.
REQ-011 avm_read / avm_write  out  1 each  access requests, mutually exclusive.
REQ-012 avm_writedata  out  32  write data.
REQ-013 avm_readdata  in  32  read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-014 avm_waitrequest  in  1  slave stall.
REQ-015 MonDReg  out  32  last read data, or last written data.
REQ-016 monitor_ready  out  1  last command completed.
REQ-017 monitor_error  out  1  last command timed out, or a command was dropped.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE.
REQ-019 SHALL accept commands only in IDLE; an accepted command clears monitor_ready and monitor_error in the next cycle.
REQ-020 SHALL apply this priority to strobes sampled together in IDLE: ocimem_b > ocimem_a > no_action_ocimem_a.
REQ-021 ocimem_a SHALL set addr<=jdo[ADDR_W-1:0]; with jdo[35]=1 it goes to READ at the new address, otherwise it stays IDLE and sets monitor_ready=1 next cycle.
REQ-022 ocimem_b SHALL latch avm_writedata<=jdo[34:3] and go to WRITE.
REQ-023 no_action_ocimem_a SHALL go to READ at the current addr.
REQ-024 SHALL drive avm_read/avm_write from the cycle after acceptance and hold them, with stable address and data, until avm_waitrequest=0.
REQ-025 On read completion, SHALL set MonDReg<=avm_readdata.
REQ-026 On write completion, SHALL set MonDReg<=writedata.
REQ-027 On any completion, SHALL set addr<=addr+1 (wrapping 2^ADDR_W-1 -> 0), set monitor_ready=1 and return to IDLE; all take effect next cycle.
REQ-028 Minimum latency SHALL be: strobe at cycle N, request at N+1, ready at N+2 when waitrequest=0 at N+1.
REQ-029 SHALL count consecutive waitrequest cycles; when the count reaches TIMEOUT_CYCLES it SHALL deassert the request, set monitor_error=1 and monitor_ready=1, leave MonDReg and addr unchanged, and return to IDLE.
REQ-030 Any strobe arriving in READ or WRITE SHALL be dropped and SHALL set monitor_error=1 (sticky until the next accepted command), with the current access unaffected.
REQ-031 SHALL ignore jdo bits 37:36 and all jdo bits not listed above.

Reset
REQ-032 Reset SHALL force state=IDLE, addr=0, MonDReg=0, avm_writedata=0, avm_read=0, avm_write=0, monitor_ready=0, monitor_error=0 and timeout count=0.
REQ-033 Reset asserted mid-access SHALL drop the request in the following cycle without completing it.
REQ-034 Strobes in the reset cycle SHALL be ignored.

Structure
REQ-035 Shared package debug_ocimem_pkg SHALL hold the state enum, the jdo field positions (WDATA_LSB=3, RDFLAG_BIT=35) and default parameter constants.
REQ-036 The timeout counter SHALL be a sub-module, debug_ocimem_timeout, with inputs clk, reset, run and clear and an output expired.

Verification
REQ-037 Load then read: ocimem_a with jdo[35]=1 and jdo[9:0]=0x010, slave readdata=0xDEADBEEF, no wait -> read of address 0x010, MonDReg=0xDEADBEEF and ready two cycles after the strobe, addr=0x011.
REQ-038 Burst write: ocimem_a with jdo[9:0]=0x3FF and jdo[35]=0, then two ocimem_b with data 0x11111111 and 0x22222222 -> writes to 0x3FF then 0x000 (wrap), addr=0x001.
REQ-039 Wait states: waitrequest high for 5 cycles on a read -> avm_read held 6 cycles with stable address, and ready with error=0.
REQ-040 Timeout: waitrequest stuck high -> request drops after 255 cycles, monitor_error=1, MonDReg and addr unchanged.
REQ-041 Collision: ocimem_b and no_action_ocimem_a in the same cycle -> only the write executes; a no_action_ocimem_a during that WRITE -> dropped, monitor_error=1.
REQ-042 Reset while avm_read is held under waitrequest -> avm_read=0 next cycle and all outputs at their reset values.
